// File: rtl/gpio_in_filter.sv
// Purpose: synchronise, debounce and edge-detect raw GPIO pad inputs, one independent lane per pin.
// Latency: a level sampled into s1 at edge E reaches o_gpio at edge E+1+debounce_cnt (E+2 when bypassed).
// Backpressure: none; every output is a free-running level or single-cycle pulse.
//
// Ports:
//   i_clk, i_nrst  - system clock, synchronous active-low reset
//   i_gpio         - raw pad inputs, asynchronous to i_clk
//   i_bypass       - per-pin debounce bypass (accept synchronised level immediately)
//   i_irq_en       - per-pin interrupt enable mask
//   i_clear        - per-pin sticky-flag clear
//   o_gpio         - debounced level
//   o_rise/o_fall  - one-cycle pulses on accepted transitions, coincident with the new o_gpio
//   o_edge_sticky  - latched edge-seen flag per pin
//   o_irq          - OR over pins of (o_edge_sticky & i_irq_en)
module gpio_in_filter #(
    parameter int width        = 12,
    parameter int debounce_cnt = 16
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic [width-1:0] i_gpio,
    input  logic [width-1:0] i_bypass,
    input  logic [width-1:0] i_irq_en,
    input  logic [width-1:0] i_clear,
    output logic [width-1:0] o_gpio,
    output logic [width-1:0] o_rise,
    output logic [width-1:0] o_fall,
    output logic [width-1:0] o_edge_sticky,
    output logic             o_irq
);

    localparam int              CW       = $clog2(debounce_cnt + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(debounce_cnt - 1);

    // Two-flop synchroniser; s1 is the only flop that sees the asynchronous pad.
    logic [width-1:0] s1;
    logic [width-1:0] s2;

    logic [width-1:0] stable;
    logic [width-1:0] stable_nxt;
    logic [width-1:0] rise;
    logic [width-1:0] fall;
    logic [width-1:0] rise_nxt;
    logic [width-1:0] fall_nxt;
    logic [width-1:0] sticky;
    logic [width-1:0] sticky_nxt;

    logic [CW-1:0]    cnt     [width];
    logic [CW-1:0]    cnt_nxt [width];

    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < width; i++) begin
            cnt_nxt[i] = '0;
            if (i_bypass[i]) begin
                // Bypass takes the synchronised level directly; any pending count is dropped.
                stable_nxt[i] = s2[i];
            end else if (s2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
            // s2 matching stable leaves cnt_nxt at 0, which is what rejects glitches.
        end
        rise_nxt   = stable_nxt & ~stable;
        fall_nxt   = ~stable_nxt & stable;
        // A new edge on the same cycle as a clear keeps the flag set.
        sticky_nxt = (sticky & ~i_clear) | rise_nxt | fall_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            rise   <= '0;
            fall   <= '0;
            sticky <= '0;
            for (int i = 0; i < width; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= i_gpio;
            s2     <= s1;
            stable <= stable_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            sticky <= sticky_nxt;
            for (int i = 0; i < width; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign o_gpio        = stable;
    assign o_rise        = rise;
    assign o_fall        = fall;
    assign o_edge_sticky = sticky;
    // Combinational from the registered flag so masking/unmasking acts in the same cycle.
    assign o_irq         = |(sticky & i_irq_en);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Purpose: directed self-checking bench for gpio_in_filter (debounce_cnt=4 and debounce_cnt=1 instances).
// Latency: inputs driven #1 after a rising edge, outputs sampled #1 after the following edges.
// Backpressure: not applicable.
module tb_gpio_in_filter;

    logic        clk;
    logic        nrst;
    logic [11:0] gpio;
    logic [11:0] bypass;
    logic [11:0] irq_en;
    logic [11:0] clear;

    logic [11:0] gpio4, rise4, fall4, sticky4;
    logic        irq4;
    logic [11:0] gpio1, rise1, fall1, sticky1;
    logic        irq1;

    int checks = 0;
    int errors = 0;

    gpio_in_filter #(.width(12), .debounce_cnt(4)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_gpio(gpio), .i_bypass(bypass),
        .i_irq_en(irq_en), .i_clear(clear),
        .o_gpio(gpio4), .o_rise(rise4), .o_fall(fall4),
        .o_edge_sticky(sticky4), .o_irq(irq4)
    );

    gpio_in_filter #(.width(12), .debounce_cnt(1)) dut1 (
        .i_clk(clk), .i_nrst(nrst), .i_gpio(gpio), .i_bypass(bypass),
        .i_irq_en(irq_en), .i_clear(clear),
        .o_gpio(gpio1), .o_rise(rise1), .o_fall(fall1),
        .o_edge_sticky(sticky1), .o_irq(irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst   = 1'b0;
        gpio   = '0;
        bypass = '0;
        irq_en = '0;
        clear  = '0;
        step();
        step();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst   = 1'b0;
        gpio   = 12'hFFF;
        bypass = '0;
        irq_en = 12'hFFF;
        clear  = '0;
        step();
        step();
        checks++; if ({gpio4, rise4, fall4, sticky4} !== 48'h0) begin errors++; $display("FAIL reset_outputs4 got %h/%h/%h/%h want 0", gpio4, rise4, fall4, sticky4); end
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL reset_irq4 got %b want 0", irq4); end
        checks++; if ({gpio1, rise1, fall1, sticky1, irq1} !== 49'h0) begin errors++; $display("FAIL reset_outputs1 got %h/%h/%h/%h/%b want 0", gpio1, rise1, fall1, sticky1, irq1); end
        do_reset();
    endtask

    task automatic test_basic_rise();
        do_reset();
        gpio[0] = 1'b1;
        step();                               // edge 1: sampled into s1
        for (int e = 2; e <= 5; e++) step();
        checks++; if (gpio4[0] !== 1'b0) begin errors++; $display("FAIL rise_early got %b want 0 after edge 5", gpio4[0]); end
        step();                               // edge 6: accepted
        checks++; if (gpio4[0] !== 1'b1) begin errors++; $display("FAIL rise_level got %b want 1 after edge 6", gpio4[0]); end
        checks++; if (rise4 !== 12'h001) begin errors++; $display("FAIL rise_pulse got %h want 001", rise4); end
        checks++; if (fall4 !== 12'h000) begin errors++; $display("FAIL rise_no_fall got %h want 000", fall4); end
        checks++; if (sticky4 !== 12'h001) begin errors++; $display("FAIL rise_sticky got %h want 001", sticky4); end
        irq_en = 12'h001;
        #1;
        checks++; if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_enabled got %b want 1", irq4); end
        irq_en = 12'h000;
        #1;
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq4); end
        step();                               // edge 7
        checks++; if (rise4 !== 12'h000) begin errors++; $display("FAIL rise_one_cycle got %h want 000", rise4); end
        checks++; if ({gpio4[0], sticky4[0]} !== 2'b11) begin errors++; $display("FAIL rise_hold got %b want 11", {gpio4[0], sticky4[0]}); end
        irq_en = 12'h001;
        #1;
        checks++; if (irq4 !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b want 1", irq4); end
        irq_en = 12'h000;
    endtask

    task automatic test_glitch();
        do_reset();
        gpio[3] = 1'b1;
        for (int e = 1; e <= 3; e++) step();
        gpio[3] = 1'b0;
        for (int e = 4; e <= 13; e++) begin
            step();
            checks++; if ({gpio4[3], rise4[3], sticky4[3]} !== 3'b000) begin errors++; $display("FAIL glitch_reject edge %0d got %b want 000", e, {gpio4[3], rise4[3], sticky4[3]}); end
        end
        // Four-cycle pulse: sampled at edges 1..4, accepted at edge 6, s2 low after edge 6.
        gpio[3] = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        gpio[3] = 1'b0;
        step();                               // edge 5
        checks++; if (gpio4[3] !== 1'b0) begin errors++; $display("FAIL pulse4_early got %b want 0", gpio4[3]); end
        step();                               // edge 6
        checks++; if ({gpio4[3], rise4[3]} !== 2'b11) begin errors++; $display("FAIL pulse4_accept got %b want 11", {gpio4[3], rise4[3]}); end
        for (int e = 7; e <= 9; e++) step();
        checks++; if ({gpio4[3], fall4[3]} !== 2'b10) begin errors++; $display("FAIL pulse4_fall_early got %b want 10", {gpio4[3], fall4[3]}); end
        step();                               // edge 10
        checks++; if ({gpio4[3], fall4[3], rise4[3]} !== 3'b010) begin errors++; $display("FAIL pulse4_fall got %b want 010", {gpio4[3], fall4[3], rise4[3]}); end
    endtask

    task automatic test_bypass();
        do_reset();
        bypass = 12'hFFF;
        gpio   = 12'hA5A;
        step();                               // edge 1
        gpio   = 12'h000;
        step();                               // edge 2
        checks++; if (gpio4 !== 12'h000) begin errors++; $display("FAIL bypass_early got %h want 000", gpio4); end
        step();                               // edge 3
        checks++; if (gpio4 !== 12'hA5A) begin errors++; $display("FAIL bypass_level got %h want A5A", gpio4); end
        checks++; if ({rise4, fall4} !== {12'hA5A, 12'h000}) begin errors++; $display("FAIL bypass_rise got %h/%h want A5A/000", rise4, fall4); end
        step();                               // edge 4
        checks++; if (gpio4 !== 12'h000) begin errors++; $display("FAIL bypass_one_cycle got %h want 000", gpio4); end
        checks++; if ({rise4, fall4} !== {12'h000, 12'hA5A}) begin errors++; $display("FAIL bypass_fall got %h/%h want 000/A5A", rise4, fall4); end
        bypass = 12'h000;
    endtask

    task automatic test_clear_collision();
        do_reset();
        gpio[5] = 1'b1;
        for (int e = 1; e <= 6; e++) step();
        gpio[5] = 1'b0;
        for (int e = 7; e <= 11; e++) step();
        checks++; if ({gpio4[5], sticky4[5]} !== 2'b11) begin errors++; $display("FAIL clr_pre got %b want 11", {gpio4[5], sticky4[5]}); end
        clear[5] = 1'b1;
        step();                               // edge 12: fall accepted with clear asserted
        checks++; if ({gpio4[5], fall4[5], sticky4[5]} !== 3'b011) begin errors++; $display("FAIL clr_collision got %b want 011", {gpio4[5], fall4[5], sticky4[5]}); end
        clear[5] = 1'b0;
        step();
        checks++; if (sticky4[5] !== 1'b1) begin errors++; $display("FAIL clr_hold got %b want 1", sticky4[5]); end
        clear[5] = 1'b1;
        step();
        clear[5] = 1'b0;
        checks++; if (sticky4[5] !== 1'b0) begin errors++; $display("FAIL clr_lone got %b want 0", sticky4[5]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        irq_en  = 12'hFFF;
        gpio[7] = 1'b1;
        for (int e = 1; e <= 4; e++) step();  // count now at 2
        nrst = 1'b0;
        step();
        checks++; if ({gpio4, rise4, fall4, sticky4} !== 48'h0) begin errors++; $display("FAIL rstmid_outputs got %h/%h/%h/%h want 0", gpio4, rise4, fall4, sticky4); end
        checks++; if (irq4 !== 1'b0) begin errors++; $display("FAIL rstmid_irq got %b want 0", irq4); end
        nrst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            checks++; if ({gpio4[7], rise4[7]} !== 2'b00) begin errors++; $display("FAIL rstmid_early edge %0d got %b want 00", e, {gpio4[7], rise4[7]}); end
        end
        step();                               // edge 6 after release
        checks++; if ({gpio4[7], rise4[7], sticky4[7], irq4} !== 4'b1111) begin errors++; $display("FAIL rstmid_rise got %b want 1111", {gpio4[7], rise4[7], sticky4[7], irq4}); end
        irq_en = 12'h000;
    endtask

    task automatic test_back_to_back();
        logic [11:0] hist [24];
        logic [11:0] exp_cur;
        logic [11:0] exp_prev;
        do_reset();
        exp_prev = 12'h000;
        for (int k = 0; k < 24; k++) begin
            gpio    = (((k / 3) % 2) == 1) ? 12'hFFF : 12'h000;
            hist[k] = gpio;
            step();
            exp_cur = (k >= 2) ? hist[k-2] : 12'h000;
            checks++; if (gpio1 !== exp_cur) begin errors++; $display("FAIL b2b_level step %0d got %h want %h", k, gpio1, exp_cur); end
            checks++; if (rise1 !== (exp_cur & ~exp_prev)) begin errors++; $display("FAIL b2b_rise step %0d got %h want %h", k, rise1, exp_cur & ~exp_prev); end
            checks++; if (fall1 !== (~exp_cur & exp_prev)) begin errors++; $display("FAIL b2b_fall step %0d got %h want %h", k, fall1, ~exp_cur & exp_prev); end
            exp_prev = exp_cur;
        end
    endtask

    initial begin
        nrst   = 1'b0;
        gpio   = '0;
        bypass = '0;
        irq_en = '0;
        clear  = '0;
        test_reset();
        test_basic_rise();
        test_glitch();
        test_bypass();
        test_clear_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
